// File: rtl/buffer_line_match_queue_pkg.sv
// Shared types and default sizing for the buffer line stages.
// Optional feature macro used by the stages: BUFFER_LINE_BYPASS_EN.
package buffer_line_pkg;

   localparam int BL_ADDR_WIDTH  = 8;
   localparam int BL_DATA_WIDTH  = 32;
   localparam int BL_DEPTH       = 4;
   localparam int BL_PTR_WIDTH   = (BL_DEPTH > 1) ? $clog2(BL_DEPTH) : 1;
   localparam int BL_COUNT_WIDTH = BL_PTR_WIDTH + 1;

   typedef logic [BL_PTR_WIDTH-1:0]   ptr_t;
   typedef logic [BL_COUNT_WIDTH-1:0] count_t;

endpackage

// File: rtl/buffer_line_match_queue_if.sv
// Producer/consumer link of a buffer line: address, data and the consumer's ack.
interface buffer_line_interface #(
   parameter int ADDR_WIDTH = 8,
   parameter int DATA_WIDTH = 32
);

   logic [ADDR_WIDTH-1:0] addr;
   logic                  addr_valid;
   logic [DATA_WIDTH-1:0] data;
   logic                  data_valid;
   logic                  data_just_matched;
   logic                  ack;

   modport producer (
      output addr, addr_valid, data, data_valid, data_just_matched,
      input  ack
   );

   modport consumer (
      input  addr, addr_valid, data, data_valid, data_just_matched,
      output ack
   );

   // Generic aliases so stages written against master/slave naming can plug in.
   modport master (
      output addr, addr_valid, data, data_valid, data_just_matched,
      input  ack
   );

   modport slave (
      input  addr, addr_valid, data, data_valid, data_just_matched,
      output ack
   );

endinterface

// File: rtl/buffer_line_match_queue_fifo.sv
// Generic synchronous FIFO with registered occupancy count; full blocks push
// even when a pop happens in the same cycle.
module buffer_line_fifo
   import buffer_line_pkg::*;
#(
   parameter int WIDTH = BL_DATA_WIDTH,
   parameter int DEPTH = BL_DEPTH
) (
   input  logic             clk,
   input  logic             reset,
   input  logic             push_i,
   input  logic [WIDTH-1:0] pushData_i,
   input  logic             pop_i,
   output logic             full_o,
   output logic             empty_o,
   output logic [WIDTH-1:0] head_o
);

   localparam int PtrW   = (DEPTH > 1) ? $clog2(DEPTH) : 1;
   localparam int CountW = PtrW + 1;

   logic [WIDTH-1:0]  mem_q [DEPTH];
   logic [PtrW-1:0]   wrPtr_q, wrPtr_d;
   logic [PtrW-1:0]   rdPtr_q, rdPtr_d;
   logic [CountW-1:0] count_q, count_d;
   logic              doPush;
   logic              doPop;

   assign full_o  = (count_q == CountW'(DEPTH));
   assign empty_o = (count_q == '0);
   assign head_o  = mem_q[rdPtr_q];
   assign doPush  = push_i && !full_o;
   assign doPop   = pop_i && !empty_o;

   // Power-of-two depth lets the pointers wrap by natural overflow.
   always_comb begin
      wrPtr_d = wrPtr_q;
      rdPtr_d = rdPtr_q;
      count_d = count_q;
      if (doPush) begin
         wrPtr_d = wrPtr_q + PtrW'(1);
      end
      if (doPop) begin
         rdPtr_d = rdPtr_q + PtrW'(1);
      end
      case ({doPush, doPop})
         2'b10:   count_d = count_q + CountW'(1);
         2'b01:   count_d = count_q - CountW'(1);
         default: count_d = count_q;
      endcase
   end

   always_ff @(posedge clk) begin
      if (reset) begin
         wrPtr_q <= '0;
         rdPtr_q <= '0;
         count_q <= '0;
      end else begin
         wrPtr_q <= wrPtr_d;
         rdPtr_q <= rdPtr_d;
         count_q <= count_d;
      end
   end

   always_ff @(posedge clk) begin
      if (doPush) begin
         mem_q[wrPtr_q] <= pushData_i;
      end
   end

endmodule

// File: rtl/buffer_line_match_queue.sv
// Pairs arriving addresses with arriving data words in order and feeds a buffer line.
// Optional: BUFFER_LINE_BYPASS_EN forwards data_in straight to the line when the data queue is empty.
module buffer_line_match_queue
   import buffer_line_pkg::*;
#(
   parameter int ADDR_WIDTH = BL_ADDR_WIDTH,
   parameter int DATA_WIDTH = BL_DATA_WIDTH,
   parameter int DEPTH      = BL_DEPTH
) (
   input  logic                  clk,
   input  logic                  reset,
   input  logic [ADDR_WIDTH-1:0] addr_in,
   input  logic                  addr_in_valid,
   output logic                  addr_in_ready,
   input  logic [DATA_WIDTH-1:0] data_in,
   input  logic                  data_in_valid,
   output logic                  data_in_ready,
   buffer_line_interface.producer line
);

   logic                  addrFull, addrEmpty;
   logic                  dataFull, dataEmpty;
   logic [ADDR_WIDTH-1:0] addrHead;
   logic [DATA_WIDTH-1:0] dataHead;
   logic                  addrPush, addrPop;
   logic                  dataPush, dataPop;
   logic                  bypass;
   logic                  pairValid;
   logic                  popPair;
   logic                  shown_q, shown_d;

   buffer_line_fifo #(
      .WIDTH (ADDR_WIDTH),
      .DEPTH (DEPTH)
   ) addrFifo (
      .clk        (clk),
      .reset      (reset),
      .push_i     (addrPush),
      .pushData_i (addr_in),
      .pop_i      (addrPop),
      .full_o     (addrFull),
      .empty_o    (addrEmpty),
      .head_o     (addrHead)
   );

   buffer_line_fifo #(
      .WIDTH (DATA_WIDTH),
      .DEPTH (DEPTH)
   ) dataFifo (
      .clk        (clk),
      .reset      (reset),
      .push_i     (dataPush),
      .pushData_i (data_in),
      .pop_i      (dataPop),
      .full_o     (dataFull),
      .empty_o    (dataEmpty),
      .head_o     (dataHead)
   );

   // A pair is complete once both heads exist; a bypassed word counts as a data head.
   always_comb begin
      bypass = 1'b0;
`ifdef BUFFER_LINE_BYPASS_EN
      bypass = dataEmpty && !addrEmpty && data_in_valid && !dataFull;
`endif
      pairValid = (!addrEmpty && !dataEmpty) || bypass;
      popPair   = line.ack && pairValid;
      addrPush  = addr_in_valid && !addrFull;
      dataPush  = data_in_valid && !dataFull && !(bypass && line.ack);
      addrPop   = popPair;
      dataPop   = popPair && !bypass;
      shown_d   = pairValid && !popPair;
   end

   always_ff @(posedge clk) begin
      if (reset) begin
         shown_q <= 1'b0;
      end else begin
         shown_q <= shown_d;
      end
   end

   assign addr_in_ready          = !addrFull;
   assign data_in_ready          = !dataFull;
   assign line.addr_valid        = !addrEmpty;
   assign line.addr              = addrEmpty ? '0 : addrHead;
   assign line.data_valid        = pairValid;
   assign line.data              = bypass ? data_in : (pairValid ? dataHead : '0);
   assign line.data_just_matched = pairValid && !shown_q;

endmodule

// File: tb/tb_buffer_line_match_queue.sv
// Scoreboard bench for buffer_line_match_queue: drivers queue expected heads,
// a negedge monitor compares the line outputs and readys against them.
module tb_buffer_line_match_queue;

   localparam int DEPTH = 4;

   logic        clk = 1'b0;
   logic        reset = 1'b1;
   logic [7:0]  addrIn = '0;
   logic        addrInValid = 1'b0;
   logic        addrInReady;
   logic [31:0] dataIn = '0;
   logic        dataInValid = 1'b0;
   logic        dataInReady;

   int testsRun = 0;
   int testsFailed = 0;

   logic [7:0]  expAddrQ [$];
   logic [31:0] expDataQ [$];
   bit          shown = 1'b0;
   bit          bypassTaken = 1'b0;
   bit          expAV, expDV, expByp;
   logic [31:0] expData;

   buffer_line_interface #(.ADDR_WIDTH(8), .DATA_WIDTH(32)) line ();

   buffer_line_match_queue #(
      .ADDR_WIDTH (8),
      .DATA_WIDTH (32),
      .DEPTH      (DEPTH)
   ) dut (
      .clk           (clk),
      .reset         (reset),
      .addr_in       (addrIn),
      .addr_in_valid (addrInValid),
      .addr_in_ready (addrInReady),
      .data_in       (dataIn),
      .data_in_valid (dataInValid),
      .data_in_ready (dataInReady),
      .line          (line)
   );

   // Free-running clock, 10 time units per cycle
   always #5 clk = ~clk;

   // Single comparison point that steps the counters
   task automatic checkOutput(input string name, input logic [31:0] actual, input logic [31:0] expected);
      testsRun++;
      if (actual !== expected) begin
         testsFailed++;
         $display("[TB] FAIL %s: got 0x%0h, expected 0x%0h at t=%0t", name, actual, expected, $time);
      end
   endtask

   // Advance n cycles, leaving time just after the active edge
   task automatic idle(input int n);
      repeat (n) @(posedge clk);
      #1;
   endtask

   // Offer one address; record it as expected once it is accepted
   task automatic sendAddr(input logic [7:0] a);
      bit rdy;
      bit done;
      done = 1'b0;
      addrIn = a;
      addrInValid = 1'b1;
      for (int k = 0; k < 50 && !done; k++) begin
         @(negedge clk);
         rdy = addrInReady;
         @(posedge clk);
         if (rdy) begin
            expAddrQ.push_back(a);
            done = 1'b1;
         end
      end
      #1 addrInValid = 1'b0;
      if (!done) begin
         testsRun++;
         testsFailed++;
         $display("[TB] FAIL addr_push_timeout: got no accept, expected accept of 0x%0h", a);
      end
   endtask

   // Offer one data word; a bypassed-and-acked word never enters the queue
   task automatic sendData(input logic [31:0] d);
      bit rdy;
      bit done;
      done = 1'b0;
      dataIn = d;
      dataInValid = 1'b1;
      for (int k = 0; k < 50 && !done; k++) begin
         @(negedge clk);
         rdy = dataInReady;
         @(posedge clk);
         if (rdy) begin
            if (bypassTaken) bypassTaken = 1'b0;
            else expDataQ.push_back(d);
            done = 1'b1;
         end
      end
      #1 dataInValid = 1'b0;
      if (!done) begin
         testsRun++;
         testsFailed++;
         $display("[TB] FAIL data_push_timeout: got no accept, expected accept of 0x%0h", d);
      end
   endtask

   // Monitor: compare every presented output against the scoreboard, then retire popped pairs
   always @(negedge clk) begin
      if (reset) begin
         shown = 1'b0;
      end else begin
         expAV  = (expAddrQ.size() != 0);
         expDV  = expAV && (expDataQ.size() != 0);
         expByp = 1'b0;
`ifdef BUFFER_LINE_BYPASS_EN
         expByp = expAV && (expDataQ.size() == 0) && dataInValid;
`endif
         checkOutput("addr_valid", 32'(line.addr_valid), 32'(expAV));
         checkOutput("data_valid", 32'(line.data_valid), 32'(expDV || expByp));
         checkOutput("addr_in_ready", 32'(addrInReady), 32'(expAddrQ.size() < DEPTH));
         checkOutput("data_in_ready", 32'(dataInReady), 32'(expDataQ.size() < DEPTH));
         if (expAV) begin
            checkOutput("head_addr", 32'(line.addr), 32'(expAddrQ[0]));
         end
         if (expDV || expByp) begin
            expData = expByp ? dataIn : expDataQ[0];
            checkOutput("head_data", line.data, expData);
            checkOutput("just_matched", 32'(line.data_just_matched), 32'(!shown));
         end else begin
            checkOutput("just_matched_idle", 32'(line.data_just_matched), 32'd0);
         end
         if (line.ack && (expDV || expByp)) begin
            void'(expAddrQ.pop_front());
            if (expByp) bypassTaken = 1'b1;
            else void'(expDataQ.pop_front());
            shown = 1'b0;
         end else begin
            shown = expDV || expByp;
         end
      end
   end

   // Hard stop in case the sequence itself stalls
   initial begin
      #200000;
      $display("[TB] FAIL watchdog: got no end of sequence, expected $finish");
      $fatal(1, "[TB] watchdog expired");
   end

   initial begin
      line.ack = 1'b0;
      repeat (2) @(posedge clk);
      #1 reset = 1'b0;

      // Reset state: outputs zeroed, both queues accepting
      @(negedge clk);
      checkOutput("reset_addr", 32'(line.addr), 32'd0);
      checkOutput("reset_data", line.data, 32'd0);
      checkOutput("reset_addr_ready", 32'(addrInReady), 32'd1);
      checkOutput("reset_data_ready", 32'(dataInReady), 32'd1);
      @(posedge clk);
      #1;

      // Address first, data three cycles later, then one ack
      sendAddr(8'h05);
      idle(2);
      sendData(32'hDEAD_BEEF);
      idle(1);
      line.ack = 1'b1;
      idle(1);
      line.ack = 1'b0;
      idle(1);

      // Data queue fills with no addresses; addresses then drain it in order
      for (int i = 0; i < 4; i++) sendData(32'h1000_0000 + 32'(i));
      @(negedge clk);
      checkOutput("data_full_ready", 32'(dataInReady), 32'd0);
      checkOutput("data_only_no_valid", 32'(line.data_valid), 32'd0);
      @(posedge clk);
      #1 line.ack = 1'b1;
      for (int i = 0; i < 4; i++) sendAddr(8'h10 + 8'(i));
      idle(1);
      line.ack = 1'b0;
      idle(1);

      // Both queues full: push and ack in the same cycle, push is refused
      for (int i = 0; i < 4; i++) sendAddr(8'h20 + 8'(i));
      for (int i = 0; i < 4; i++) sendData(32'h2000 + 32'(i));
      addrIn = 8'hAA;
      addrInValid = 1'b1;
      line.ack = 1'b1;
      @(negedge clk);
      checkOutput("full_push_ready", 32'(addrInReady), 32'd0);
      @(posedge clk);
      #1 addrInValid = 1'b0;
      line.ack = 1'b0;
      @(negedge clk);
      checkOutput("ready_after_pop", 32'(addrInReady), 32'd1);
      checkOutput("head_after_refused_push", 32'(line.addr), 32'h21);
      @(posedge clk);
      #1 line.ack = 1'b1;
      idle(3);
      line.ack = 1'b0;
      idle(1);

      // Ack held while no pair is complete is ignored
      sendAddr(8'h40);
      line.ack = 1'b1;
      idle(3);
      @(negedge clk);
      checkOutput("ack_ignored_addr_valid", 32'(line.addr_valid), 32'd1);
      checkOutput("ack_ignored_addr", 32'(line.addr), 32'h40);
      @(posedge clk);
      #1;
      sendData(32'h4444_4444);
      idle(1);
      line.ack = 1'b0;
      idle(1);

      // Reset with three pairs queued discards everything
      for (int i = 0; i < 3; i++) begin
         sendAddr(8'h50 + 8'(i));
         sendData(32'h5000 + 32'(i));
      end
      reset = 1'b1;
      @(posedge clk);
      expAddrQ.delete();
      expDataQ.delete();
      @(negedge clk);
      checkOutput("midreset_addr_valid", 32'(line.addr_valid), 32'd0);
      checkOutput("midreset_data_valid", 32'(line.data_valid), 32'd0);
      checkOutput("midreset_just_matched", 32'(line.data_just_matched), 32'd0);
      checkOutput("midreset_addr_ready", 32'(addrInReady), 32'd1);
      checkOutput("midreset_data_ready", 32'(dataInReady), 32'd1);
      @(posedge clk);
      #1 reset = 1'b0;
      idle(2);

`ifdef BUFFER_LINE_BYPASS_EN
      // Bypass: data arrives to an empty data queue with the address waiting and ack high
      sendAddr(8'h60);
      dataIn = 32'h1234;
      dataInValid = 1'b1;
      line.ack = 1'b1;
      #1;
      checkOutput("bypass_data", line.data, 32'h1234);
      checkOutput("bypass_data_valid", 32'(line.data_valid), 32'd1);
      checkOutput("bypass_just_matched", 32'(line.data_just_matched), 32'd1);
      @(posedge clk);
      if (bypassTaken) bypassTaken = 1'b0;
      else expDataQ.push_back(32'h1234);
      #1 dataInValid = 1'b0;
      line.ack = 1'b0;
      @(negedge clk);
      checkOutput("bypass_after_addr_valid", 32'(line.addr_valid), 32'd0);
      checkOutput("bypass_after_data_valid", 32'(line.data_valid), 32'd0);
      @(posedge clk);
      #1;
      idle(1);
`endif

      $display("[TB] %0d tests run, %0d failed", testsRun, testsFailed);
      $finish;
   end

endmodule
